ps2_scan_decoder: RTL and testbench

- Downstream consumer of the PS/2 byte receiver; sits between the receiver and the LED/display/UART logic on the Basys board.
- Turns the raw scan-code byte stream (Set 2) into single-cycle key events: make/break, extended flag, Shift/Caps state, ASCII where mappable.
- Removes the receiver's ambiguity where the break prefix 0xF0 is "re-shown" as the previous key.

---
 rtl/ps2_pkg.sv | 49 ++++
 rtl/ps2_ascii_lut.sv | 101 ++++++++++
 rtl/ps2_scan_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 Set 2 scan-code decoder:
//   - decoder FSM state encoding
//   - protocol prefix bytes and special key codes
//   - list of keyboard response bytes that never form key events
// -----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GOT_E0   = 3'd1,
    ST_GOT_F0   = 3'd2,
    ST_GOT_E0F0 = 3'd3,
    ST_SKIP_E1  = 3'd4
  } ps2_state_e;

  // Protocol prefixes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Modifier keys
  localparam logic [7:0] LSHIFT = 8'h12;
  localparam logic [7:0] RSHIFT = 8'h59;
  localparam logic [7:0] CAPS   = 8'h58;

  // Non-alphanumeric keys with an ASCII mapping
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BKSP  = 8'h66;

  // Keyboard responses (ACK, BAT result, echo, resend, errors) that show up
  // in the byte stream but are not key presses.
  localparam int FILTER_N = 6;
  localparam logic [7:0] FILTER_CODES [FILTER_N] = '{
    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF
  };

  function automatic logic is_filtered(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < FILTER_N; i++) begin
      if (code == FILTER_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// -----------------------------------------------------------------------------
// ps2_ascii_lut
// Combinational Set 2 scan code to ASCII translation for non-extended keys.
// Ports:
//   i_code   [7:0]  scan code (prefix-stripped)
//   i_shift         either Shift held
//   i_caps          Caps Lock toggle state
//   o_ascii  [7:0]  translated character, 0x00 when unmapped
//   o_mapped        1 when i_code has an ASCII mapping
// -----------------------------------------------------------------------------
module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_shift,
  input  logic       i_caps,
  output logic [7:0] o_ascii,
  output logic       o_mapped
);

  // Letter index 0..25 ('a'..'z'); 31 marks "not a letter".
  logic [4:0]  w_letter_idx;
  // Digit row: {shifted char, plain char}; zero when not a digit key.
  logic [15:0] w_digit_pair;

  // NOTE: every signal written in an always_comb gets a default at the top,
  // otherwise any path that skips an assignment infers a latch.
  always_comb begin
    w_letter_idx = 5'd31;
    unique case (i_code)
      8'h1C: w_letter_idx = 5'd0;   // a
      8'h32: w_letter_idx = 5'd1;   // b
      8'h21: w_letter_idx = 5'd2;   // c
      8'h23: w_letter_idx = 5'd3;   // d
      8'h24: w_letter_idx = 5'd4;   // e
      8'h2B: w_letter_idx = 5'd5;   // f
      8'h34: w_letter_idx = 5'd6;   // g
      8'h33: w_letter_idx = 5'd7;   // h
      8'h43: w_letter_idx = 5'd8;   // i
      8'h3B: w_letter_idx = 5'd9;   // j
      8'h42: w_letter_idx = 5'd10;  // k
      8'h4B: w_letter_idx = 5'd11;  // l
      8'h3A: w_letter_idx = 5'd12;  // m
      8'h31: w_letter_idx = 5'd13;  // n
      8'h44: w_letter_idx = 5'd14;  // o
      8'h4D: w_letter_idx = 5'd15;  // p
      8'h15: w_letter_idx = 5'd16;  // q
      8'h2D: w_letter_idx = 5'd17;  // r
      8'h1B: w_letter_idx = 5'd18;  // s
      8'h2C: w_letter_idx = 5'd19;  // t
      8'h3C: w_letter_idx = 5'd20;  // u
      8'h2A: w_letter_idx = 5'd21;  // v
      8'h1D: w_letter_idx = 5'd22;  // w
      8'h22: w_letter_idx = 5'd23;  // x
      8'h35: w_letter_idx = 5'd24;  // y
      8'h1A: w_letter_idx = 5'd25;  // z
      default: w_letter_idx = 5'd31;
    endcase
  end

  always_comb begin
    w_digit_pair = 16'h0000;
    unique case (i_code)
      8'h16: w_digit_pair = {8'h21, 8'h31};  // ! 1
      8'h1E: w_digit_pair = {8'h40, 8'h32};  // @ 2
      8'h26: w_digit_pair = {8'h23, 8'h33};  // # 3
      8'h25: w_digit_pair = {8'h24, 8'h34};  // $ 4
      8'h2E: w_digit_pair = {8'h25, 8'h35};  // % 5
      8'h36: w_digit_pair = {8'h5E, 8'h36};  // ^ 6
      8'h3D: w_digit_pair = {8'h26, 8'h37};  // & 7
      8'h3E: w_digit_pair = {8'h2A, 8'h38};  // * 8
      8'h46: w_digit_pair = {8'h28, 8'h39};  // ( 9
      8'h45: w_digit_pair = {8'h29, 8'h30};  // ) 0
      default: w_digit_pair = 16'h0000;
    endcase
  end

  always_comb begin
    o_ascii  = 8'h00;
    o_mapped = 1'b0;
    if (w_letter_idx != 5'd31) begin
      // Shift and Caps cancel each other for letters.
      o_ascii  = ((i_shift ^ i_caps) ? 8'h41 : 8'h61) + {3'b000, w_letter_idx};
      o_mapped = 1'b1;
    end else if (w_digit_pair != 16'h0000) begin
      // Caps Lock does not apply to the digit row.
      o_ascii  = i_shift ? w_digit_pair[15:8] : w_digit_pair[7:0];
      o_mapped = 1'b1;
    end else if (i_code == KEY_SPACE) begin
      o_ascii  = 8'h20;
      o_mapped = 1'b1;
    end else if (i_code == KEY_ENTER) begin
      o_ascii  = 8'h0D;
      o_mapped = 1'b1;
    end else if (i_code == KEY_BKSP) begin
      o_ascii  = 8'h08;
      o_mapped = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// -----------------------------------------------------------------------------
// ps2_scan_decoder
// Turns the PS/2 Set 2 byte stream from the receiver into single-cycle key
// events with make/break and extended flags, tracks Shift / Caps Lock, and
// translates printable make events to ASCII.
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   code_in [7:0]       received scan byte, qualified by code_valid
//   code_valid          one-cycle strobe per received byte
//   key_code [7:0]      scan code of the last event, prefixes stripped
//   key_ext             last event carried an 0xE0 prefix
//   key_break           last event was a release
//   key_valid           one-cycle strobe, event fields valid
//   ascii [7:0]         ASCII of last make event, 0x00 if unmapped
//   ascii_valid         one-cycle strobe for mapped non-extended make events
//   shift_active        either Shift key held
//   caps_lock           Caps Lock toggle state
// -----------------------------------------------------------------------------
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int PAUSE_LEN      = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic [7:0] ascii,
  output logic       ascii_valid,
  output logic       shift_active,
  output logic       caps_lock
);

  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SKIP_W = (PAUSE_LEN > 0) ? $clog2(PAUSE_LEN + 1) : 1;

  ps2_state_e        r_state;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [SKIP_W-1:0] r_skip_cnt;
  logic              r_lshift;
  logic              r_rshift;
  logic              r_caps;
  logic              r_caps_held;

  logic [7:0]        r_key_code;
  logic              r_key_ext;
  logic              r_key_break;
  logic              r_key_valid;
  logic [7:0]        r_ascii;
  logic              r_ascii_valid;

  ps2_state_e        w_state_nxt;
  logic [SKIP_W-1:0] w_skip_nxt;
  logic              w_emit;
  logic [7:0]        w_ev_code;
  logic              w_ev_ext;
  logic              w_ev_brk;
  logic              w_tmo_hit;
  logic [7:0]        w_lut_ascii;
  logic              w_lut_mapped;

  // A byte arriving in the expiry cycle wins: the timeout only applies when
  // no byte is presented.
  assign w_tmo_hit = (r_state != ST_IDLE) && !code_valid &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip_cnt;
    w_emit      = 1'b0;
    w_ev_code   = code_in;
    w_ev_ext    = 1'b0;
    w_ev_brk    = 1'b0;
    if (code_valid) begin
      unique case (r_state)
        ST_IDLE: begin
          if (code_in == PS2_EXT) begin
            w_state_nxt = ST_GOT_E0;
          end else if (code_in == PS2_BRK) begin
            w_state_nxt = ST_GOT_F0;
          end else if (code_in == PS2_PAUSE) begin
            w_state_nxt = ST_SKIP_E1;
            w_skip_nxt  = SKIP_W'(PAUSE_LEN);
          end else if (!is_filtered(code_in)) begin
            w_emit = 1'b1;
          end
        end
        ST_GOT_E0: begin
          if (code_in == PS2_BRK) begin
            w_state_nxt = ST_GOT_E0F0;
          end else if (code_in != PS2_EXT) begin
            // A repeated E0 keeps waiting; anything else completes the event.
            w_emit      = 1'b1;
            w_ev_ext    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          w_emit      = 1'b1;
          w_ev_brk    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_GOT_E0F0: begin
          w_emit      = 1'b1;
          w_ev_ext    = 1'b1;
          w_ev_brk    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_SKIP_E1: begin
          // The Pause sequence is reported once, as a make of 0xE1, when its
          // last byte is swallowed.
          if (r_skip_cnt <= SKIP_W'(1)) begin
            w_emit      = 1'b1;
            w_ev_code   = PS2_PAUSE;
            w_skip_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_skip_nxt = r_skip_cnt - SKIP_W'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_tmo_hit) begin
      w_state_nxt = ST_IDLE;
      w_skip_nxt  = '0;
    end
  end

  // Uses the modifier state from before this event is applied.
  ps2_ascii_lut u_ascii_lut (
    .i_code   (w_ev_code),
    .i_shift  (r_lshift | r_rshift),
    .i_caps   (r_caps),
    .o_ascii  (w_lut_ascii),
    .o_mapped (w_lut_mapped)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_tmo_cnt     <= '0;
      r_skip_cnt    <= '0;
      r_lshift      <= 1'b0;
      r_rshift      <= 1'b0;
      r_caps        <= 1'b0;
      r_caps_held   <= 1'b0;
      r_key_code    <= 8'h00;
      r_key_ext     <= 1'b0;
      r_key_break   <= 1'b0;
      r_key_valid   <= 1'b0;
      r_ascii       <= 8'h00;
      r_ascii_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_skip_cnt <= w_skip_nxt;

      if (code_valid || r_state == ST_IDLE || w_tmo_hit) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end

      r_key_valid   <= w_emit;
      r_ascii_valid <= w_emit && !w_ev_brk && !w_ev_ext && w_lut_mapped;

      if (w_emit) begin
        r_key_code  <= w_ev_code;
        r_key_ext   <= w_ev_ext;
        r_key_break <= w_ev_brk;
        if (!w_ev_brk) begin
          r_ascii <= (!w_ev_ext && w_lut_mapped) ? w_lut_ascii : 8'h00;
        end
        if (!w_ev_ext) begin
          if (w_ev_code == LSHIFT) r_lshift <= !w_ev_brk;
          if (w_ev_code == RSHIFT) r_rshift <= !w_ev_brk;
          if (w_ev_code == CAPS) begin
            // caps_held suppresses toggling on typematic repeats of the make.
            if (w_ev_brk) begin
              r_caps_held <= 1'b0;
            end else begin
              if (!r_caps_held) r_caps <= ~r_caps;
              r_caps_held <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign key_code     = r_key_code;
  assign key_ext      = r_key_ext;
  assign key_break    = r_key_break;
  assign key_valid    = r_key_valid;
  assign ascii        = r_ascii;
  assign ascii_valid  = r_ascii_valid;
  assign shift_active = r_lshift | r_rshift;
  assign caps_lock    = r_caps;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_ps2_scan_decoder
// Directed scenarios with literal expectations, then a randomized byte stream.
// A behavioural model tracks pending prefixes as flags and a bytes-left count,
// and a compare process checks every DUT output against it each cycle.
// -----------------------------------------------------------------------------
module tb_ps2_scan_decoder;

  localparam int T = 20;
  localparam int P = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] code_in = 8'h00;
  logic       code_valid = 1'b0;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic [7:0] ascii;
  logic       ascii_valid;
  logic       shift_active;
  logic       caps_lock;

  ps2_scan_decoder #(.TIMEOUT_CYCLES(T), .PAUSE_LEN(P)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_break    (key_break),
    .key_valid    (key_valid),
    .ascii        (ascii),
    .ascii_valid  (ascii_valid),
    .shift_active (shift_active),
    .caps_lock    (caps_lock)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ev_count = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [7:0] letter_codes [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  string digit_s = "1234567890";
  string sym_s   = "!@#$%^&*()";
  string lower_s = "abcdefghijklmnopqrstuvwxyz";
  string upper_s = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";

  // Expected registered outputs
  logic       m_kv, m_av, m_ext, m_brk;
  logic [7:0] m_code, m_ascii;
  // Expected key state
  bit m_lsh, m_rsh, m_caps, m_caps_held;
  // Pending sequence: flags for seen prefixes, bytes left in Pause
  bit m_saw_ext, m_saw_brk;
  int m_pause_left;
  int m_gap;

  function automatic void char_of(input logic [7:0] c, input bit sh, input bit cp,
                                  output logic [7:0] a, output bit hit);
    a = 8'h00;
    hit = 1'b0;
    for (int i = 0; i < 26; i++)
      if (c == letter_codes[i]) begin
        a = (sh != cp) ? upper_s[i] : lower_s[i];
        hit = 1'b1;
      end
    for (int i = 0; i < 10; i++)
      if (c == digit_codes[i]) begin
        a = sh ? sym_s[i] : digit_s[i];
        hit = 1'b1;
      end
    if (c == 8'h29) begin a = 8'h20; hit = 1'b1; end
    if (c == 8'h5A) begin a = 8'h0D; hit = 1'b1; end
    if (c == 8'h66) begin a = 8'h08; hit = 1'b1; end
  endfunction

  task automatic model_emit(input logic [7:0] c, input bit ext, input bit brk);
    logic [7:0] a;
    bit hit;
    m_kv = 1'b1;
    m_code = c;
    m_ext = ext;
    m_brk = brk;
    if (!brk) begin
      char_of(c, m_lsh | m_rsh, m_caps, a, hit);
      m_ascii = (hit && !ext) ? a : 8'h00;
      m_av = hit && !ext;
    end
    if (!ext) begin
      if (c == 8'h12) m_lsh = !brk;
      if (c == 8'h59) m_rsh = !brk;
      if (c == 8'h58) begin
        if (!brk && !m_caps_held) m_caps = !m_caps;
        m_caps_held = !brk;
      end
    end
  endtask

  task automatic model_step();
    logic [7:0] b;
    if (!rst_n) begin
      m_kv = 0; m_av = 0; m_ext = 0; m_brk = 0; m_code = 0; m_ascii = 0;
      m_lsh = 0; m_rsh = 0; m_caps = 0; m_caps_held = 0;
      m_saw_ext = 0; m_saw_brk = 0; m_pause_left = 0; m_gap = 0;
      return;
    end
    m_kv = 1'b0;
    m_av = 1'b0;
    if (code_valid) begin
      b = code_in;
      m_gap = 0;
      if (m_pause_left > 0) begin
        m_pause_left--;
        if (m_pause_left == 0) model_emit(8'hE1, 1'b0, 1'b0);
      end else if (m_saw_brk) begin
        model_emit(b, m_saw_ext, 1'b1);
        m_saw_ext = 0;
        m_saw_brk = 0;
      end else if (b == 8'hE0) begin
        m_saw_ext = 1;
      end else if (b == 8'hF0) begin
        m_saw_brk = 1;
      end else if (m_saw_ext) begin
        model_emit(b, 1'b1, 1'b0);
        m_saw_ext = 0;
      end else if (b == 8'hE1) begin
        m_pause_left = P;
      end else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
        model_emit(b, 1'b0, 1'b0);
      end
    end else if (m_saw_ext || m_saw_brk || m_pause_left > 0) begin
      // A prefix may wait T idle cycles; the T-th idle cycle abandons it.
      m_gap++;
      if (m_gap == T) begin
        m_saw_ext = 0;
        m_saw_brk = 0;
        m_pause_left = 0;
        m_gap = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("outputs",
            {10'd0, key_valid, ascii_valid, shift_active, caps_lock, key_ext, key_break, key_code, ascii},
            {10'd0, m_kv, m_av, m_lsh | m_rsh, m_caps, m_ext, m_brk, m_code, m_ascii});
      if (key_valid) ev_count++;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    code_in = b;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    code_in = 8'($urandom_range(0, 255));
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_code();
    int r;
    r = $urandom_range(0, 99);
    if (r < 10) return 8'hE0;
    if (r < 20) return 8'hF0;
    if (r < 23) return 8'hE1;
    if (r < 28) begin
      logic [7:0] f [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
      return f[$urandom_range(0, 5)];
    end
    if (r < 40) begin
      logic [7:0] m [3] = '{8'h12, 8'h59, 8'h58};
      return m[$urandom_range(0, 2)];
    end
    if (r < 65) return letter_codes[$urandom_range(0, 25)];
    if (r < 80) return digit_codes[$urandom_range(0, 9)];
    if (r < 88) begin
      logic [7:0] s [7] = '{8'h29, 8'h5A, 8'h66, 8'h75, 8'h6B, 8'h74, 8'h72};
      return s[$urandom_range(0, 6)];
    end
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- main
  initial begin
    int ev0;
    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmp_en = 1'b1;
    check("reset_outputs",
          {10'd0, key_valid, ascii_valid, shift_active, caps_lock, key_ext, key_break, key_code, ascii}, 32'd0);

    // Plain make of 'a', then single-cycle strobe, then break
    send(8'h1C, 0);
    check("make_1C", {key_valid, key_code, key_ext, key_break, ascii, ascii_valid},
          {1'b1, 8'h1C, 1'b0, 1'b0, 8'h61, 1'b1});
    check("model_pin_1C", m_ascii, 8'h61);
    @(posedge clk); #1;
    check("strobe_1cycle", {key_valid, ascii_valid}, 2'b00);
    send(8'hF0, 0);
    check("no_event_on_F0", key_valid, 1'b0);
    send(8'h1C, 0);
    check("break_1C", {key_valid, key_code, key_break, ascii_valid, ascii},
          {1'b1, 8'h1C, 1'b1, 1'b0, 8'h61});

    // Extended make/break
    send(8'hE0, 1); send(8'h75, 0);
    check("ext_make_75", {key_valid, key_code, key_ext, key_break, ascii_valid},
          {1'b1, 8'h75, 1'b1, 1'b0, 1'b0});
    send(8'hE0, 1); send(8'hF0, 0); send(8'h75, 0);
    check("ext_break_75", {key_valid, key_code, key_ext, key_break, ascii_valid},
          {1'b1, 8'h75, 1'b1, 1'b1, 1'b0});

    // Shift
    send(8'h12, 1);
    check("lshift_on", shift_active, 1'b1);
    send(8'h1C, 0);
    check("shift_A", {ascii_valid, ascii}, {1'b1, 8'h41});
    check("model_pin_A", m_ascii, 8'h41);
    send(8'hF0, 0); send(8'h12, 0);
    check("lshift_off", shift_active, 1'b0);
    send(8'h1C, 0);
    check("unshift_a", ascii, 8'h61);

    // Caps with typematic repeat, digit unaffected
    send(8'h58, 1); send(8'h58, 2); send(8'hF0, 0); send(8'h58, 0);
    check("caps_once", caps_lock, 1'b1);
    send(8'h16, 0);
    check("digit_1_caps", {ascii_valid, ascii}, {1'b1, 8'h31});

    // Pause sequence: one event only
    @(posedge clk); #1;
    ev0 = ev_count;
    for (int i = 0; i < 8; i++) send(pause_seq[i], 0);
    check("pause_code", {key_valid, key_code, key_ext, key_break}, {1'b1, 8'hE1, 1'b0, 1'b0});
    repeat (3) @(posedge clk); #1;
    check("pause_one_event", ev_count - ev0, 1);

    // Timeout: prefix abandoned after T idle cycles; byte in expiry cycle kept
    send(8'hF0, 1); send(8'h1C, T);
    check("timeout_make", {key_valid, key_code, key_break}, {1'b1, 8'h1C, 1'b0});
    send(8'hF0, 1); send(8'h1C, T - 1);
    check("expiry_break", {key_valid, key_code, key_break}, {1'b1, 8'h1C, 1'b1});

    // Filtered response
    send(8'hAA, 1);
    check("filter_AA", key_valid, 1'b0);

    // Reset mid-sequence
    send(8'hE0, 1);
    do_reset();
    check("reset_mid_noevent", {key_valid, caps_lock, key_code}, 10'd0);
    send(8'h75, 0);
    check("after_reset_75", {key_valid, key_code, key_ext, key_break}, {1'b1, 8'h75, 1'b0, 1'b0});

    // Randomized stream
    for (int n = 0; n < 2500; n++) begin
      int r;
      int g;
      r = $urandom_range(0, 999);
      if (r < 4) do_reset();
      r = $urandom_range(0, 99);
      if (r < 60) g = 0;
      else if (r < 92) g = $urandom_range(1, 3);
      else if (r < 96) g = T - 1;
      else g = T + $urandom_range(0, 3);
      send(rand_code(), g);
    end
    repeat (T + 5) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
